rvfi_ref_lockstep_checker: RTL

//  Synthesisable lockstep checker between a core's RVFI retirement stream and a reference-model stream.

---
 rtl/rvfi_ref_lockstep_checker.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rvfi_ref_lockstep_checker.sv
// Lockstep checker: buffers core RVFI retirements in order and compares each one against
// a reference-model packet. MODE 0 turns it into a one-cycle mirror of the core stream.
module rvfi_ref_lockstep_checker #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8,
  parameter int MODE  = 1,
  parameter int PKT_W = 64 + 2*XLEN + 38
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NRET-1:0]        core_valid_i,
  input  logic [NRET*PKT_W-1:0]  core_pkt_i,
  input  logic                   ref_valid_i,
  output logic                   ref_ready_o,
  input  logic [PKT_W-1:0]       ref_pkt_i,
  output logic [NRET-1:0]        mirror_valid_o,
  output logic [NRET*PKT_W-1:0]  mirror_pkt_o,
  input  logic [31:0]            irq_i,
  output logic                   irq_req_o,
  output logic [31:0]            irq_o,
  input  logic                   irq_ack_i,
  output logic                   mismatch_o,
  output logic                   error_o,
  output logic [63:0]            err_order_o,
  output logic                   overflow_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = PKT_W - 64;
  // Order sits in the top 64 bits and is excluded from the field compare.
  localparam logic [PKT_W-1:0] CMP_MASK = {{64{1'b0}}, {CW{1'b1}}};

  typedef enum logic {IRQ_IDLE, IRQ_REQ} irq_state_e;

  logic [PKT_W-1:0]      r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [63:0]           r_exp_order;
  logic                  r_exp_valid;
  logic                  r_mismatch;
  logic                  r_error;
  logic [63:0]           r_err_order;
  logic                  r_overflow;
  logic [NRET-1:0]       r_mirror_valid;
  logic [NRET*PKT_W-1:0] r_mirror_pkt;
  irq_state_e            r_irq_state;
  logic                  r_irq_req;
  logic [31:0]           r_irq;

  logic [LW-1:0]         w_cnt;
  logic [AW-1:0]         w_waddr [NRET];
  logic [63:0]           w_lane_order [NRET];
  logic [LW-1:0]         w_free;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [PKT_W-1:0]      w_head;
  logic                  w_cmp_fail;
  logic                  w_ord_err;
  logic [63:0]           w_ord_bad;
  logic [63:0]           w_exp_order;
  logic                  w_exp_valid;

  generate
    for (genvar gi = 0; gi < NRET; gi++) begin : g_lane
      assign w_lane_order[gi] = core_pkt_i[gi*PKT_W + CW +: 64];
    end
  endgenerate

  // Valid lanes are packed densely: each lane's slot is the count of valid lanes below it.
  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < NRET; k++) begin
      w_waddr[k] = r_wr_ptr + w_cnt[AW-1:0];
      if (core_valid_i[k]) w_cnt = w_cnt + LW'(1);
    end
  end

  assign ref_ready_o = (MODE == 1) && (r_level != '0);
  assign w_pop       = ref_valid_i && ref_ready_o;
  assign w_free      = LW'(DEPTH) - r_level + LW'(w_pop);
  assign w_push      = (MODE == 1) && (w_cnt != '0) && (w_cnt <= w_free);
  assign w_drop      = (MODE == 1) && (w_cnt > w_free);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_cmp_fail  = w_pop && (|((w_head ^ ref_pkt_i) & CMP_MASK));

  // Orders must run consecutively across lanes as well as across cycles.
  always_comb begin
    w_ord_err   = 1'b0;
    w_ord_bad   = '0;
    w_exp_order = r_exp_order;
    w_exp_valid = r_exp_valid;
    for (int k = 0; k < NRET; k++) begin
      if (core_valid_i[k]) begin
        if (w_exp_valid && !w_ord_err && (w_lane_order[k] != w_exp_order)) begin
          w_ord_err = 1'b1;
          w_ord_bad = w_lane_order[k];
        end
        w_exp_order = w_lane_order[k] + 64'd1;
        w_exp_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      for (int k = 0; k < NRET; k++) begin
        if (core_valid_i[k]) r_mem[w_waddr[k]] <= core_pkt_i[k*PKT_W +: PKT_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_exp_order    <= '0;
      r_exp_valid    <= 1'b0;
      r_mismatch     <= 1'b0;
      r_error        <= 1'b0;
      r_err_order    <= '0;
      r_overflow     <= 1'b0;
      r_mirror_valid <= '0;
      r_mirror_pkt   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + w_cnt[AW-1:0];
        r_exp_order <= w_exp_order;
        r_exp_valid <= w_exp_valid;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level    <= r_level + (w_push ? w_cnt : '0) - LW'(w_pop);
      r_mismatch <= w_cmp_fail;
      if (w_cmp_fail || (w_push && w_ord_err) || w_drop) r_error <= 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      // Only the first failure is recorded; a popped head is older than anything pushed now.
      if (!r_error) begin
        if (w_cmp_fail)
          r_err_order <= w_head[PKT_W-1 -: 64];
        else if (w_push && w_ord_err)
          r_err_order <= w_ord_bad;
      end
      r_mirror_valid <= (MODE == 0) ? core_valid_i : '0;
      r_mirror_pkt   <= (MODE == 0) ? core_pkt_i : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_state <= IRQ_IDLE;
      r_irq_req   <= 1'b0;
      r_irq       <= '0;
    end else begin
      case (r_irq_state)
        IRQ_IDLE: begin
          if (irq_i != r_irq) begin
            r_irq       <= irq_i;
            r_irq_req   <= 1'b1;
            r_irq_state <= IRQ_REQ;
          end
        end
        IRQ_REQ: begin
          if (irq_ack_i) begin
            r_irq_req   <= 1'b0;
            r_irq_state <= IRQ_IDLE;
          end
        end
        default: r_irq_state <= IRQ_IDLE;
      endcase
    end
  end

  assign mirror_valid_o = r_mirror_valid;
  assign mirror_pkt_o   = r_mirror_pkt;
  assign irq_req_o      = r_irq_req;
  assign irq_o          = r_irq;
  assign mismatch_o     = r_mismatch;
  assign error_o        = r_error;
  assign err_order_o    = r_err_order;
  assign overflow_o     = r_overflow;
  assign level_o        = r_level;

endmodule
